envelope_follower: RTL
======================

# envelope_follower

Downstream stage of the Hilbert envelope detector. Consumes the raw per-sample envelope magnitude, smooths it with an attack/release one-pole filter, tracks a held-and-decaying peak, and decimates both to a low-rate (level, peak) pair. The pair is offered to the display/visualizer logic over a valid/ready handshake.

## Interface
- IN_WIDTH, 18: envelope input width (signed, from the detector)
- OUT_WIDTH, 18: level/peak output width; must be ≥ IN_WIDTH-1
- ATTACK_SHIFT, 2: smoother coefficient 2^-ATTACK_SHIFT when input > level
- RELEASE_SHIFT, 8: smoother coefficient 2^-RELEASE_SHIFT when input ≤ level; also the fractional bits FRAC of the smoother state
- HOLD_SAMPLES, 4096: accepted samples the peak is held before decay starts
- DECAY_SHIFT, 4: peak decay step is max(1, peak >> DECAY_SHIFT) per accepted sample
- DECIM, 256: accepted samples per output snapshot; ≥ 2
- clk, in, 1: single clock domain
- rst, in, 1: asynchronous, active-low reset (asserted when 0)
- clear, in, 1: synchronous clear of all state
- in_valid, in, 1: env_in carries a sample this cycle; no backpressure to upstream
- env_in, in, IN_WIDTH: signed envelope sample
- level_out, out, OUT_WIDTH: smoothed level snapshot
- peak_out, out, OUT_WIDTH: peak snapshot
- out_valid, out, 1: snapshot pending
- out_ready, in, 1: consumer accepts snapshot
- overrun, out, 1: sticky; a pending snapshot was overwritten

## Operation
- Input conditioning: x = 0 if env_in < 0, else env_in (unsigned, IN_WIDTH-1 bits).
- Smoother state s_fx is unsigned, IN_WIDTH-1+FRAC bits. On in_valid: d = (x << FRAC) − s_fx, signed. If d > 0, then s_fx += d >>> ATTACK_SHIFT. Otherwise, s_fx += d >>> RELEASE_SHIFT. The shift is arithmetic. Level = s_fx >> FRAC (truncate), zero-extended to OUT_WIDTH.
- Peak on in_valid, evaluated in this order:
  - if x ≥ peak: peak ← x and hold_cnt ← HOLD_SAMPLES
  - else if hold_cnt ≠ 0: hold_cnt−−
  - else: peak ← max(x, peak − max(1, peak >> DECAY_SHIFT))
- Decimation counter counts accepted samples 0..DECIM−1 and wraps. On the sample where the counter equals DECIM−1, the output registers load the post-update level and peak, and out_valid is set.
- Output FSM has two states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1. Transitions to EMPTY on out_ready with no snapshot load that cycle.
  - Snapshot load while in FULL and out_ready = 0: the new snapshot overwrites (latest wins), overrun ← 1, and the FSM stays in FULL.
  - Snapshot load and out_ready in the same cycle: the new snapshot loads, the FSM stays in FULL, and overrun is not set.
- clear takes priority over in_valid. It zeroes s_fx, peak, hold_cnt, the decimation counter, and overrun, and moves the FSM to EMPTY. The input sample presented that cycle is discarded.
- Reset values: level_out = 0, peak_out = 0, out_valid = 0, overrun = 0; all internal state is 0.

## Timing
- The smoother, peak, and counter update on the clock edge that samples in_valid = 1.
- Snapshot latency: out_valid is high in the cycle after the edge that accepted the DECIM-th sample.
- level_out and peak_out are registered and stable while out_valid = 1 and no new load occurs.
- Back-to-back in_valid on every cycle is supported. The block never stalls its input.
- An asynchronous reset asserted mid-operation clears everything immediately. After rst deasserts, the first snapshot is produced DECIM accepted samples later.

## Structure
- Package envelope_pkg holds:
  - the OUT_WIDTH-based typedef level_t
  - the out_state_t enum {EMPTY, FULL}
  - the default width and shift localparams shared with the detector
- One sub-module, peak_hold_decay, contains the peak register, hold counter, and decay arithmetic. It has ports clk, rst, clear, in_valid, x, and peak.
- The smoother, decimation counter, and output FSM stay in the top module.

## Test plan
- Reset with rst = 0, then release → level_out = 0, peak_out = 0, out_valid = 0, overrun = 0. No out_valid appears before DECIM samples.
- DECIM = 4, ATTACK_SHIFT = 2, FRAC = 8; env_in = 1000 for 4 samples → one snapshot with level_out = 683 and peak_out = 1000. Internally s_fx steps 64000, 112000, 148000, 175000.
- HOLD_SAMPLES = 3, DECAY_SHIFT = 4; feed 1600 then zeros → peak holds 1600 for 3 samples, then decays to 1500, then 1407, then 1320.
- out_ready = 0 across two snapshots → second snapshot overwrites, overrun = 1. Then pulse out_ready → out_valid = 0, and overrun stays 1 until clear.
- Snapshot load coincident with out_ready → out_valid stays 1 and new values appear. Negative input env_in = −5 → treated as 0 (level decays, peak unaffected).
- Assert rst mid-decimation, then assert clear during the next run → all outputs and state return to zero immediately. The counter restarts, so the next snapshot comes after exactly DECIM further samples.

Source files
------------

// File: rtl/envelope_pkg.sv
// envelope_pkg: shared widths, shifts and types for the envelope detector chain.
package envelope_pkg;
   localparam int DEF_IN_WIDTH      = 18;
   localparam int DEF_OUT_WIDTH     = 18;
   localparam int DEF_ATTACK_SHIFT  = 2;
   localparam int DEF_RELEASE_SHIFT = 8;
   localparam int DEF_HOLD_SAMPLES  = 4096;
   localparam int DEF_DECAY_SHIFT   = 4;
   localparam int DEF_DECIM         = 256;
   typedef logic [DEF_OUT_WIDTH-1:0] level_t;
   typedef enum logic {EMPTY, FULL} out_state_t;
endpackage

// File: rtl/envelope_follower_peak_hold_decay.sv
// peak_hold_decay: peak tracker that holds for a fixed sample count, then decays geometrically.
module peak_hold_decay #(
   parameter int XW           = 17,
   parameter int HOLD_SAMPLES = 4096,
   parameter int DECAY_SHIFT  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          in_valid,
   input  logic [XW-1:0] x,
   output logic [XW-1:0] peak
);
   localparam int HW = $clog2(HOLD_SAMPLES + 1);
   logic [HW-1:0] hold_cnt;
   logic [XW-1:0] step, decayed;
   // decay always moves by at least one so small peaks still reach zero
   always_comb begin
      step    = (peak >> DECAY_SHIFT) == '0 ? XW'(1) : peak >> DECAY_SHIFT;
      decayed = peak - step;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         peak     <= '0;
         hold_cnt <= '0;
      end else if (clear) begin
         peak     <= '0;
         hold_cnt <= '0;
      end else if (in_valid) begin
         if (x >= peak) begin
            peak     <= x;
            hold_cnt <= HW'(HOLD_SAMPLES);
         end else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - HW'(1);
         else
            peak <= x > decayed ? x : decayed;
      end
endmodule

// File: rtl/envelope_follower.sv
// envelope_follower: attack/release smoother plus held peak, decimated to a (level, peak)
// snapshot offered over valid/ready with latest-wins overwrite.
module envelope_follower
   import envelope_pkg::*;
#(
   parameter int IN_WIDTH      = DEF_IN_WIDTH,
   parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
   parameter int ATTACK_SHIFT  = DEF_ATTACK_SHIFT,
   parameter int RELEASE_SHIFT = DEF_RELEASE_SHIFT,
   parameter int HOLD_SAMPLES  = DEF_HOLD_SAMPLES,
   parameter int DECAY_SHIFT   = DEF_DECAY_SHIFT,
   parameter int DECIM         = DEF_DECIM
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  env_in,
   output logic [OUT_WIDTH-1:0] level_out,
   output logic [OUT_WIDTH-1:0] peak_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overrun
);
   localparam int XW   = IN_WIDTH - 1;
   localparam int FRAC = RELEASE_SHIFT;
   localparam int SW   = XW + FRAC;
   localparam int CW   = $clog2(DECIM);
   logic [XW-1:0]        x, peak;
   logic [SW-1:0]        s_fx, s_nxt;
   logic signed [SW:0]   d, d_sh;
   logic [CW-1:0]        cnt;
   logic                 load, sel;
   logic [OUT_WIDTH-1:0] peak_q;
   out_state_t           state;
   always_comb begin
      x     = env_in[IN_WIDTH-1] ? '0 : env_in[XW-1:0];
      d     = $signed({1'b0, x, {FRAC{1'b0}}}) - $signed({1'b0, s_fx});
      d_sh  = d > 0 ? d >>> ATTACK_SHIFT : d >>> RELEASE_SHIFT;
      s_nxt = SW'($signed({1'b0, s_fx}) + d_sh);
      load  = in_valid && cnt == CW'(DECIM - 1);
   end
   peak_hold_decay #(.XW(XW), .HOLD_SAMPLES(HOLD_SAMPLES), .DECAY_SHIFT(DECAY_SHIFT)) u_peak (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .x(x), .peak(peak)
   );
   // on a load edge the peak register itself holds the post-update value, so the
   // snapshot follows it for one cycle (sel) and is frozen into peak_q at the next edge
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         s_fx      <= '0;
         cnt       <= '0;
         level_out <= '0;
         peak_q    <= '0;
         sel       <= 1'b0;
         overrun   <= 1'b0;
         state     <= EMPTY;
      end else if (clear) begin
         s_fx      <= '0;
         cnt       <= '0;
         level_out <= '0;
         peak_q    <= '0;
         sel       <= 1'b0;
         overrun   <= 1'b0;
         state     <= EMPTY;
      end else begin
         if (in_valid) begin
            s_fx <= s_nxt;
            cnt  <= load ? '0 : cnt + CW'(1);
         end
         if (load) begin
            level_out <= OUT_WIDTH'(s_nxt[SW-1:FRAC]);
            sel       <= 1'b1;
            state     <= FULL;
            if (state == FULL && !out_ready) overrun <= 1'b1;
         end else begin
            if (sel) begin
               peak_q <= OUT_WIDTH'(peak);
               sel    <= 1'b0;
            end
            if (state == FULL && out_ready) state <= EMPTY;
         end
      end
   assign out_valid = state == FULL;
   assign peak_out  = sel ? OUT_WIDTH'(peak) : peak_q;
endmodule
